pipelined_carry_select_adder: RTL and testbench
===============================================

// Module: pipelined_carry_select_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor. Successor to the 4-bit carry-select block.
//  WIDTH is split into BLOCK_W-bit carry-select blocks. Registers sit every BLOCKS_PER_STAGE blocks.
//  A valid/ready handshake with bubble collapse lets it sit in streaming datapaths between producer and consumer.
// PARAMETERS
//  WIDTH             32  operand/sum width; must be a multiple of BLOCK_W*BLOCKS_PER_STAGE
//  BLOCK_W            4  bits per carry-select block
//  BLOCKS_PER_STAGE   2  carry-select blocks evaluated combinationally per pipeline stage
//  derived: NUM_BLOCKS=WIDTH/BLOCK_W, NUM_STAGES=NUM_BLOCKS/BLOCKS_PER_STAGE (latency)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands present
//  in_ready   out  1      adder accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (ignored when sub=1)
//  sub        in   1      1: a-b (b inverted, carry-in forced 1); 0: a+b+cin
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
// BEHAVIOUR
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Each carry-select block computes sum/carry for carry-in 0 and 1. The incoming carry selects between them.
//  - Stage s handles blocks [s*BPS .. s*BPS+BPS-1]. Its carry-in is the carry registered by stage s-1.
//    Stage 0 carry-in is (sub ? 1 : cin).
//  - Operand slices for later stages are skewed (delayed) and done sum slices are carried forward, so one
//    transaction stays aligned across stages. The last stage register drives sum/cout/out_valid directly.
//  - Latency: exactly NUM_STAGES cycles from input transfer to out_valid when there is no back-pressure.
//  - Throughput: 1 result/cycle.
//  - Flow control per stage: ld[N-1] = !v[N-1] | out_ready; ld[s] = !v[s] | ld[s+1]; in_ready = ld[0].
//    A stage with ld=0 holds its data.
//    Bubbles collapse: an empty stage loads even while downstream stalls.
//    in_ready is combinational from out_ready (no skid buffer).
//  - Stage valid bits: v[0] <= in_valid when ld[0]; v[s] <= v[s-1] when ld[s].
//    Data registers load only when the valid in is 1.
//  - Simultaneous out transfer and new input on a full pipe: both occur in the same cycle, no loss, no duplicate.
//  - Reset (async, any time, including mid-stream): all v=0, out_valid=0, sum=0, cout=0.
//    In-flight transactions are dropped. in_ready=1 from the first cycle after reset release.
//  - sum wraps modulo 2^WIDTH. Carry beyond the MSB appears only on cout.
//  - out_valid, sum and cout stay stable while out_valid & !out_ready.
// CONFIGURATION
//  CSA_STATUS_EN defined: adds outputs zero (1: sum==0) and ovf (signed overflow).
//    ovf = carry into MSB XOR carry out of MSB.
//    Both are registered with sum, reset to 0, and held under stall.
//  CSA_STATUS_EN undefined: ports zero/ovf are absent and no extra logic is generated.
// STRUCTURE
//  csa_pkg: default widths, a localparam function for NUM_STAGES, and an elaboration check on divisibility.
//  Sub-module csa_block #(BLOCK_W): combinational dual ripple adders plus a carry mux, ports a,b,cin,sum,cout.
//  It is instantiated NUM_BLOCKS times in generate loops. The top level holds pipeline, skew and handshake.
// TESTING  (WIDTH=16, BLOCK_W=4, BLOCKS_PER_STAGE=2 -> latency 2)
//  1 a=16'h00FF b=16'h0001 cin=0 sub=0, out_ready=1 -> 2 cycles later sum=16'h0100 cout=0.
//  2 a=16'hFFFF b=16'h0001 sub=0 -> sum=16'h0000 cout=1. With CSA_STATUS_EN: zero=1 ovf=0.
//    a=16'h7FFF b=16'h0001 -> sum=16'h8000 ovf=1.
//  3 a=16'h0005 b=16'h0007 sub=1 -> sum=16'hFFFE cout=0.
//    a=16'h1234 b=16'h1234 sub=1 -> sum=16'h0000 cout=1.
//  4 Stream of 10 random ops with out_ready held 0 for 5 cycles, then 1:
//    -> in_ready drops after 2 accepted ops, results come in order, none lost or duplicated, output stable while stalled.
//  5 Send one op, idle 1 cycle, then send a second; hold out_ready=0 -> both stages fill (bubble collapsed) before in_ready=0.
//  6 Assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0 and sum=0 immediately.
//    After release, no stale result ever appears.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared defaults and configuration helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam int unsigned DefaultWidth          = 32;
  localparam int unsigned DefaultBlockW         = 4;
  localparam int unsigned DefaultBlocksPerStage = 2;

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned block_w,
                                             input int unsigned blocks_per_stage);
    return width / (block_w * blocks_per_stage);
  endfunction

  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned block_w,
                                input int unsigned blocks_per_stage);
    return (width != 0) && (block_w != 0) && (blocks_per_stage != 0) &&
           ((width % (block_w * blocks_per_stage)) == 0);
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two ripple adders (carry-in 0 and 1) and a carry-driven select.
module csa_block #(
  parameter int unsigned BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] sum,
  output logic               cout
);

  logic [BLOCK_W-1:0] sum0, sum1;
  logic               c0, c1;

  always_comb begin
    c0   = 1'b0;
    c1   = 1'b1;
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < int'(BLOCK_W); i++) begin
      sum0[i] = a[i] ^ b[i] ^ c0;
      sum1[i] = a[i] ^ b[i] ^ c1;
      c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
    sum  = cin ? sum1 : sum0;
    cout = cin ? c1 : c0;
  end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control and bubble collapse.
// Define CSA_STATUS_EN to add registered zero and signed-overflow outputs.
module pipelined_carry_select_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH            = DefaultWidth,
  parameter int unsigned BLOCK_W          = DefaultBlockW,
  parameter int unsigned BLOCKS_PER_STAGE = DefaultBlocksPerStage
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_STATUS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned NUM_BLOCKS = WIDTH / BLOCK_W;
  localparam int unsigned NUM_STAGES = num_stages(WIDTH, BLOCK_W, BLOCKS_PER_STAGE);
  localparam int unsigned STAGE_W    = BLOCK_W * BLOCKS_PER_STAGE;
  localparam int unsigned LAST       = NUM_STAGES - 1;

  if (!cfg_ok(WIDTH, BLOCK_W, BLOCKS_PER_STAGE)) begin : g_bad_cfg
    $error("WIDTH must be a nonzero multiple of BLOCK_W*BLOCKS_PER_STAGE");
  end

  logic [NUM_STAGES-1:0]            v_q, c_q, ld;
  logic [NUM_STAGES-1:0]            st_vin, st_cin, st_cout;
  logic [NUM_STAGES-1:0][WIDTH-1:0] op_a, op_b, sum_in, sum_d;
  logic [NUM_STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0]                 blk_sum;
  logic [NUM_BLOCKS-1:0]            blk_co;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] SliceMask = WIDTH'({STAGE_W{1'b1}}) << (s * STAGE_W);

    if (s == 0) begin : g_first
      // Subtraction is a + ~b + 1; the inverted operand travels down the skew registers.
      assign op_a[s]   = a;
      assign op_b[s]   = sub ? ~b : b;
      assign st_cin[s] = sub | cin;
      assign st_vin[s] = in_valid;
      assign sum_in[s] = '0;
    end else begin : g_next
      assign op_a[s]   = a_q[s-1];
      assign op_b[s]   = b_q[s-1];
      assign st_cin[s] = c_q[s-1];
      assign st_vin[s] = v_q[s-1];
      assign sum_in[s] = sum_q[s-1];
    end

    for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
      localparam int unsigned K = s * BLOCKS_PER_STAGE + j;
      logic blk_cin;
      if (j == 0) begin : g_cin_stage
        assign blk_cin = st_cin[s];
      end else begin : g_cin_chain
        assign blk_cin = blk_co[K-1];
      end
      csa_block #(.BLOCK_W(BLOCK_W)) u_blk (
        .a    (op_a[s][K*BLOCK_W +: BLOCK_W]),
        .b    (op_b[s][K*BLOCK_W +: BLOCK_W]),
        .cin  (blk_cin),
        .sum  (blk_sum[K*BLOCK_W +: BLOCK_W]),
        .cout (blk_co[K])
      );
    end

    assign st_cout[s] = blk_co[s*BLOCKS_PER_STAGE + BLOCKS_PER_STAGE - 1];
    // Slices above this stage are still zero, so OR-ing in the new slice is enough.
    assign sum_d[s]   = sum_in[s] | (blk_sum & SliceMask);
  end

  // Back-pressure ripples from the output; an empty stage always loads.
  always_comb begin
    logic down_ld;
    down_ld = out_ready;
    ld      = '0;
    for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
      down_ld = !v_q[s] || down_ld;
      ld[s]   = down_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      sum_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
        if (ld[s]) begin
          v_q[s] <= st_vin[s];
        end
        if (ld[s] && st_vin[s]) begin
          c_q[s]   <= st_cout[s];
          sum_q[s] <= sum_d[s];
          a_q[s]   <= op_a[s];
          b_q[s]   <= op_b[s];
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = c_q[LAST];

  // The last stage's operand copies have no consumer.
  logic unused_ops;
  assign unused_ops = ^{a_q[LAST], b_q[LAST]};

`ifdef CSA_STATUS_EN
  logic zero_q, ovf_q, msb_carry;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign msb_carry = op_a[LAST][WIDTH-1] ^ op_b[LAST][WIDTH-1] ^ blk_sum[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ld[LAST] && st_vin[LAST]) begin
      zero_q <= (sum_d[LAST] == '0);
      ovf_q  <= msb_carry ^ st_cout[LAST];
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for pipelined_carry_select_adder at WIDTH=16 (two-stage latency).
module tb_pipelined_carry_select_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef CSA_STATUS_EN
  logic         zero, ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  int   n_acc  = 0;
  exp_t exp_q[$];

  logic [15:0] t4_a   [10] = '{16'h0001, 16'h00F0, 16'h8000, 16'hFFFF, 16'h0100,
                               16'h0000, 16'h1234, 16'hABCD, 16'h8000, 16'h0FFF};
  logic [15:0] t4_b   [10] = '{16'h0002, 16'h0010, 16'h8000, 16'h0000, 16'h0001,
                               16'h0001, 16'h4321, 16'h1111, 16'h0001, 16'h0001};
  logic        t4_c   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t4_sub [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] t4_sum [10] = '{16'h0003, 16'h0100, 16'h0000, 16'h0000, 16'h00FF,
                               16'hFFFF, 16'h5555, 16'hBCDE, 16'h7FFF, 16'h1000};
  logic        t4_co  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        t4_z   [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t4_o   [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  pipelined_carry_select_adder #(
    .WIDTH            (16),
    .BLOCK_W          (4),
    .BLOCKS_PER_STAGE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_STATUS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic z, input logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.z = z;
    e.o = o;
    return e;
  endfunction

  // Drive one operand set at a negedge and hold it until accepted at a posedge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic ts, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("accepted", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    n_acc++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops on every output transfer and checks stability while stalled.
  initial begin
    logic        stalled;
    logic [15:0] hs;
    logic        hc;
    exp_t        e;
    stalled = 1'b0;
    hs      = '0;
    hc      = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_sum", 32'(sum), 32'(hs));
          chk("hold_cout", 32'(cout), 32'(hc));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(e.s));
            chk("cout", 32'(cout), 32'(e.c));
`ifdef CSA_STATUS_EN
            chk("zero", 32'(zero), 32'(e.z));
            chk("ovf", 32'(ovf), 32'(e.o));
`endif
          end
        end
        stalled = out_valid && !out_ready;
        hs      = sum;
        hc      = cout;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #1 rst_n  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency of exactly two cycles.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b0));
    idle();
    #2;
    chk("latency_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #2;
    chk("latency_on_time", 32'(out_valid), 32'd1);
    drain();

    // Wrap, signed overflow, subtraction and carry-in handling.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b0, 1'b1));
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    send(16'h1234, 16'h1234, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0));
    send(16'h0001, 16'h0001, 1'b1, 1'b0, mk(16'h0003, 1'b0, 1'b0, 1'b0));
    send(16'h0010, 16'h0001, 1'b1, 1'b1, mk(16'h000F, 1'b1, 1'b0, 1'b0));
    idle();
    drain();

    // Stream of ten with the consumer stalled for five cycles.
    @(negedge clk);
    out_ready = 1'b0;
    n_acc     = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(t4_a[i], t4_b[i], t4_c[i], t4_sub[i],
               mk(t4_sum[i], t4_co[i], t4_z[i], t4_o[i]));
        end
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(n_acc), 32'd2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubble collapse: an idle slot must not block the second op under stall.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, mk(16'h0303, 1'b0, 1'b0, 1'b0));
    idle();
    send(16'h4000, 16'h4000, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b0, 1'b1));
    idle();
    #1;
    chk("bubble_full_ready", 32'(in_ready), 32'd0);
    chk("bubble_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with two ops in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, mk(16'h1010, 1'b0, 1'b0, 1'b0));
    idle();
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    send(16'h0042, 16'h0008, 1'b0, 1'b0, mk(16'h004A, 1'b0, 1'b0, 1'b0));
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
